// File: rtl/ntt_seq_pkg.sv
// Shared constants and state encoding for the NTT pass sequencer.
// Also used by the attached 7-bit pass counter.
package ntt_seq_pkg;

    localparam int PASS_LEN   = 128;
    localparam int NUM_STAGES = 11;
    localparam int GAP_CYCLES = 4;
    localparam int CW         = $clog2(PASS_LEN);
    localparam int SW         = $clog2(NUM_STAGES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        GAP,
        DONE
    } seq_state_e;

    // Width of a down-counter that must hold g-1.
    function automatic int gap_w(input int g);
        return (g > 1) ? $clog2(g) : 1;
    endfunction

endpackage

// File: rtl/ntt_pass_sequencer_gap_timer.sv
// Loadable down-counter timing the idle gap between passes.
// zero is high once the loaded count has run out.
module ntt_gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes precedence; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ntt_pass_sequencer.sv
// Per-stage pass initiator for the n=2048 NTT datapath.
// Starts the pass counter, shadows its count, flags divergence.
module ntt_pass_sequencer #(
    parameter int PASS_LEN   = ntt_seq_pkg::PASS_LEN,
    parameter int NUM_STAGES = ntt_seq_pkg::NUM_STAGES,
    parameter int GAP_CYCLES = ntt_seq_pkg::GAP_CYCLES,
    parameter int CW         = $clog2(PASS_LEN),
    parameter int SW         = $clog2(NUM_STAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          abort,
    input  logic [CW-1:0] cnt_in,
    output logic          stage_start,
    output logic [SW-1:0] stage_idx,
    output logic          run_valid,
    output logic          busy,
    output logic          done,
    output logic          err
);

    import ntt_seq_pkg::*;

    localparam int GW = gap_w(GAP_CYCLES);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] LAST_CNT = CW'(PASS_LEN - 1);
    localparam logic [SW-1:0] LAST_STG = SW'(NUM_STAGES - 1);
    localparam logic [GW-1:0] GAP_LOAD =
        GW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    seq_state_e    state_q;
    seq_state_e    state_d;
    logic [CW-1:0] shadow_q;
    logic [CW-1:0] shadow_d;
    logic [SW-1:0] stage_idx_q;
    logic [SW-1:0] stage_idx_d;
    logic          err_q;
    logic          err_d;
    logic          post_chk_q;
    logic          post_chk_d;
    logic          stage_start_q;
    logic          stage_start_d;
    logic          run_valid_q;
    logic          run_valid_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;

    logic          gap_load;
    logic          gap_zero;
    logic [SW-1:0] stage_nxt;
    logic          run_mis;
    logic          post_mis;

    // Drain-gap timer, loaded as a pass ends.
    ntt_gap_timer #(
        .W(GW)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (gap_load),
        .load_val(GAP_LOAD),
        .zero    (gap_zero)
    );

    // Stage index advance saturates at the last stage.
    always_comb begin
        stage_nxt = stage_idx_q;
        if (stage_idx_q != LAST_STG) begin
            stage_nxt = stage_idx_q + 1'b1;
        end
    end

    // Count check: live count must track the shadow, then read 0 after wrap.
    always_comb begin
        run_mis  = (state_q == RUN) && (cnt_in != shadow_q);
        post_mis = post_chk_q && (cnt_in != '0);
    end

    // Next-state, shadow, stage index and sticky error.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        stage_idx_d = stage_idx_q;
        err_d       = err_q;
        post_chk_d  = 1'b0;
        gap_load    = 1'b0;

        if (run_mis || post_mis) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d     = START;
                    stage_idx_d = '0;
                    err_d       = 1'b0;
                end
            end
            START: begin
                shadow_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                shadow_d = shadow_q + 1'b1;
                if (shadow_q == LAST_CNT) begin
                    post_chk_d = 1'b1;
                    if (stage_idx_q == LAST_STG) begin
                        state_d = DONE;
                    end else if (HAS_GAP) begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end else begin
                        state_d     = START;
                        stage_idx_d = stage_nxt;
                    end
                end
            end
            GAP: begin
                if (gap_zero) begin
                    state_d     = START;
                    stage_idx_d = stage_nxt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel wins over every transition and freezes the error flag.
        if (abort) begin
            state_d     = IDLE;
            shadow_d    = shadow_q;
            stage_idx_d = stage_idx_q;
            err_d       = err_q;
            post_chk_d  = 1'b0;
            gap_load    = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        stage_start_d = (state_d == START);
        run_valid_d   = (state_d == RUN);
        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            stage_idx_q   <= '0;
            err_q         <= 1'b0;
            post_chk_q    <= 1'b0;
            stage_start_q <= 1'b0;
            run_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            stage_idx_q   <= stage_idx_d;
            err_q         <= err_d;
            post_chk_q    <= post_chk_d;
            stage_start_q <= stage_start_d;
            run_valid_q   <= run_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign stage_start = stage_start_q;
    assign stage_idx   = stage_idx_q;
    assign run_valid   = run_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
